// File: rtl/alu_seq_n.sv
// Multi-cycle ALU with valid/ready handshakes. Shifts run one bit per cycle and MUL
// is an iterative shift-add. A non-one-hot OpCode completes at once with err set.
`timescale 1ns/1ps
module alu_seq_n #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [12:0]      OpCode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [3:0]       Flags,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] K_SHL = 2'd0;
  localparam logic [1:0] K_SHR = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;
  localparam logic [1:0] K_MUL = 2'd3;

  // One extra counter bit so a full WIDTH-step multiply fits.
  localparam int CW = SHW + 1;

  function automatic logic [3:0] mk_flags(input logic cf, input logic ovf,
                                          input logic [WIDTH-1:0] r);
    mk_flags = {cf, ovf, r[WIDTH-1], (r == {WIDTH{1'b0}})};
  endfunction

  logic [1:0]         state_q, state_d, kind_q, kind_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d, z_q, z_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   opb_s, r_s, work_nx_s;
  logic [WIDTH:0]     add_s, sub_s, msum_s;
  logic [2*WIDTH:0]   mwide_s;
  logic [2*WIDTH-1:0] acc_nx_s;
  logic [CW-1:0]      amt_s;
  logic [3:0]         f_s;
  logic [1:0]         kind_s;
  logic               e_s, go_exec_s, ovf_add_s, ovf_sub_s, out_bit_s;

  // INX/DCX reuse the add/sub paths with a constant 1 operand.
  assign opb_s     = (OpCode[2] | OpCode[3]) ? {{(WIDTH-1){1'b0}}, 1'b1} : y;
  assign add_s     = {1'b0, x} + {1'b0, opb_s};
  assign sub_s     = {1'b0, x} - {1'b0, opb_s};
  assign ovf_add_s = (x[WIDTH-1] == opb_s[WIDTH-1]) && (add_s[WIDTH-1] != x[WIDTH-1]);
  assign ovf_sub_s = (x[WIDTH-1] != opb_s[WIDTH-1]) && (sub_s[WIDTH-1] != x[WIDTH-1]);
  assign amt_s     = {1'b0, y[SHW-1:0]};

  // Decode the incoming operation: single-cycle result or launch of an iterative op.
  always_comb begin
    r_s       = {WIDTH{1'b0}};
    f_s       = 4'b0001;
    e_s       = 1'b0;
    go_exec_s = 1'b0;
    kind_s    = K_MUL;
    case (OpCode)
      13'h0001, 13'h0004: begin
        r_s = add_s[WIDTH-1:0];
        f_s = mk_flags(add_s[WIDTH], ovf_add_s, add_s[WIDTH-1:0]);
      end
      13'h0002, 13'h0008: begin
        r_s = sub_s[WIDTH-1:0];
        f_s = mk_flags(sub_s[WIDTH], ovf_sub_s, sub_s[WIDTH-1:0]);
      end
      13'h0010: begin
        r_s = x;
        f_s = mk_flags(sub_s[WIDTH], ovf_sub_s, sub_s[WIDTH-1:0]);
      end
      13'h0020, 13'h0040, 13'h0080: begin
        r_s       = x;
        f_s       = mk_flags(1'b0, 1'b0, x);
        go_exec_s = (amt_s != {CW{1'b0}});
        kind_s    = OpCode[5] ? K_SHL : (OpCode[6] ? K_SHR : K_SRA);
      end
      13'h0100: begin r_s = x & y; f_s = mk_flags(1'b0, 1'b0, x & y); end
      13'h0200: begin r_s = x | y; f_s = mk_flags(1'b0, 1'b0, x | y); end
      13'h0400: begin r_s = x ^ y; f_s = mk_flags(1'b0, 1'b0, x ^ y); end
      13'h0800: begin r_s = ~x;    f_s = mk_flags(1'b0, 1'b0, ~x);    end
      13'h1000: begin
        go_exec_s = 1'b1;
        kind_s    = K_MUL;
      end
      default: begin
        r_s = {WIDTH{1'b0}};
        f_s = 4'b0001;
        e_s = 1'b1;
      end
    endcase
  end

  // One iteration step: single-bit shift of work_q, or one shift-add of the accumulator.
  always_comb begin
    msum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, work_q} : {(WIDTH+1){1'b0}});
    mwide_s  = {msum_s, acc_q[WIDTH-1:0]};
    acc_nx_s = mwide_s[2*WIDTH:1];
    case (kind_q)
      K_SHL: begin work_nx_s = {work_q[WIDTH-2:0], 1'b0};         out_bit_s = work_q[WIDTH-1]; end
      K_SHR: begin work_nx_s = {1'b0, work_q[WIDTH-1:1]};         out_bit_s = work_q[0];       end
      K_SRA: begin work_nx_s = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; out_bit_s = work_q[0];    end
      default: begin work_nx_s = work_q;                          out_bit_s = 1'b0;            end
    endcase
  end

  // Next-state logic for the IDLE/EXEC/DONE sequencer and result registers.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    acc_d   = acc_q;
    z_d     = z_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (go_exec_s) begin
            state_d = S_EXEC;
            kind_d  = kind_s;
            work_d  = x;
            cnt_d   = (kind_s == K_MUL) ? CW'(WIDTH) : amt_s;
            acc_d   = (kind_s == K_MUL) ? {{WIDTH{1'b0}}, y} : {(2*WIDTH){1'b0}};
          end else begin
            state_d = S_DONE;
            z_d     = r_s;
            flags_d = f_s;
            err_d   = e_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (kind_q == K_MUL) begin
          acc_d = acc_nx_s;
        end else begin
          work_d = work_nx_s;
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (kind_q == K_MUL) begin
            z_d     = acc_nx_s[WIDTH-1:0];
            flags_d = mk_flags(acc_nx_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}},
                               acc_nx_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}},
                               acc_nx_s[WIDTH-1:0]);
          end else begin
            z_d     = work_nx_s;
            flags_d = mk_flags(out_bit_s, 1'b0, work_nx_s);
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_SHL;
      cnt_q   <= {CW{1'b0}};
      work_q  <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      z_q     <= {WIDTH{1'b0}};
      flags_q <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign z         = z_q;
  assign Flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// Scoreboard bench for alu_seq_n (WIDTH=32): the driver pushes expected results and
// latencies, a negedge monitor pops and compares whenever out_valid rises.
`timescale 1ns/1ps
module tb_alu_seq_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;
  logic [12:0] OpCode = 13'd0;
  logic        in_ready, out_valid, err;
  logic [31:0] z;
  logic [3:0]  Flags;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  f;
    logic        e;
    int          lat;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   or_mode = 0;

  alu_seq_n #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .OpCode(OpCode), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .Flags(Flags), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic on the operation's definition.
  function automatic void model(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f,
                                output logic e, output int lat);
    longint s;
    logic [63:0] p;
    logic [31:0] fr, bb;
    logic cf, ovf;
    int k;
    k = int'(b[4:0]);
    r = 32'd0; f = 4'b0001; e = 1'b1; lat = 0; cf = 1'b0; ovf = 1'b0;
    if ($countones(op) == 1) begin
      e  = 1'b0;
      bb = (op[2] | op[3]) ? 32'd1 : b;
      if (op[0] | op[2]) begin
        p   = {32'd0, a} + {32'd0, bb};
        r   = p[31:0];
        cf  = p[32];
        s   = longint'($signed(a)) + longint'($signed(bb));
        ovf = (s != longint'($signed(r)));
      end else if (op[1] | op[3] | op[4]) begin
        r   = a - bb;
        cf  = (a < bb);
        s   = longint'($signed(a)) - longint'($signed(bb));
        ovf = (s != longint'($signed(r)));
      end else if (op[5]) begin
        r = a << k; cf = (k > 0) ? a[32-k] : 1'b0; lat = k;
      end else if (op[6]) begin
        r = a >> k; cf = (k > 0) ? a[k-1] : 1'b0; lat = k;
      end else if (op[7]) begin
        r = $signed(a) >>> k; cf = (k > 0) ? a[k-1] : 1'b0; lat = k;
      end else if (op[8]) begin
        r = a & b;
      end else if (op[9]) begin
        r = a | b;
      end else if (op[10]) begin
        r = a ^ b;
      end else if (op[11]) begin
        r = ~a;
      end else begin
        p   = {32'd0, a} * {32'd0, b};
        r   = p[31:0];
        cf  = (p[63:32] != 32'd0);
        ovf = cf;
        lat = 32;
      end
      fr = r;
      if (op[4]) r = a;
      f = {cf, ovf, fr[31], (fr == 32'd0)};
    end
  endfunction

  // Called at posedge+1; returns one edge after the accept edge.
  task automatic issue(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ez, input logic [3:0] ef, input logic ee, input int elat);
    int g;
    exp_t ex;
    g = 0;
    while (!in_ready && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", g);
    end else begin
      in_valid = 1'b1; x = a; y = b; OpCode = op;
      @(posedge clk); #1;
      ex.z = ez; ex.f = ef; ex.e = ee; ex.lat = elat; ex.edge_n = cyc;
      sb.push_back(ex);
      in_valid = 1'b0; x = $urandom; y = $urandom; OpCode = 13'($urandom);
    end
  endtask

  task automatic issue_m(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r; logic [3:0] f; logic e; int lat;
    model(op, a, b, r, f, e, lat);
    issue(op, a, b, r, f, e, lat);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb.size() != 0 || out_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
    end
  endtask

  // Consumer side: out_ready pattern selected by or_mode.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        1: out_ready = 1'b0;
        2: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare on first out_valid cycle, then check hold and handshake rules.
  initial begin
    logic pv, po, he;
    logic [31:0] hz;
    logic [3:0]  hf;
    exp_t ex;
    pv = 1'b0; po = 1'b0; hz = 32'd0; hf = 4'd0; he = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; po = 1'b0;
      end else begin
        if (out_valid) begin
          if (!pv) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_result: out_valid with nothing outstanding, z=0x%0h", z);
            end else begin
              ex = sb.pop_front();
              check("z", z, ex.z);
              check("flags", 32'(Flags), 32'(ex.f));
              check("err", 32'(err), 32'(ex.e));
              check("latency", 32'(cyc - ex.edge_n), 32'(ex.lat));
            end
            hz = z; hf = Flags; he = err;
          end else begin
            check("hold_z", z, hz);
            check("hold_flags", 32'(Flags), 32'(hf));
            check("hold_err", 32'(err), 32'(he));
          end
          check("in_ready_in_done", 32'(in_ready), 32'd0);
        end else begin
          if (pv && po) check("in_ready_after_done", 32'(in_ready), 32'd1);
          if (sb.size() > 0) check("in_ready_busy", 32'(in_ready), 32'd0);
        end
        pv = out_valid;
        po = out_ready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] op;
    logic [31:0] a, b;
    int sel;
    or_mode = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_z", z, 32'd0);
    check("rst_flags", 32'(Flags), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    issue(13'h0001, 32'h90000180, 32'h04000140, 32'h940002C0, 4'b0010, 1'b0, 0);
    issue(13'h0002, 32'h90000180, 32'h04000140, 32'h8C000040, 4'b0010, 1'b0, 0);
    issue(13'h0010, 32'h00001234, 32'h00001234, 32'h00001234, 4'b0001, 1'b0, 0);
    issue(13'h0020, 32'h90000180, 32'h00000003, 32'h80000C00, 4'b0010, 1'b0, 3);
    issue(13'h0040, 32'h0000000F, 32'h00000002, 32'h00000003, 4'b1000, 1'b0, 2);
    issue(13'h0080, 32'h90000180, 32'h00000003, 32'hF2000030, 4'b0010, 1'b0, 3);
    issue(13'h1000, 32'h00010000, 32'h00010003, 32'h00030000, 4'b1100, 1'b0, 32);
    issue(13'h0003, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0001, 1'b1, 0);
    issue(13'h0000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0001, 1'b1, 0);
    issue(13'h0020, 32'h80000000, 32'h00000020, 32'h80000000, 4'b0010, 1'b0, 0);
    issue(13'h0004, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 4'b1001, 1'b0, 0);
    issue(13'h0008, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1010, 1'b0, 0);
    issue(13'h0008, 32'h80000000, 32'h00000000, 32'h7FFFFFFF, 4'b0100, 1'b0, 0);
    issue(13'h0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110, 1'b0, 0);
    issue(13'h0800, 32'h0F0F0F0F, 32'h00000000, 32'hF0F0F0F0, 4'b0010, 1'b0, 0);
    wait_idle();

    // Backpressure: result must sit unchanged while out_ready is low.
    or_mode = 1; out_ready = 1'b0;
    @(posedge clk); #1;
    issue(13'h0001, 32'h90000180, 32'h04000140, 32'h940002C0, 4'b0010, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("bp_out_valid_held", 32'(out_valid), 32'd1);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    or_mode = 2; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    or_mode = 0;

    // Reset during the tenth multiply step discards the operation.
    wait_idle();
    issue_m(13'h1000, 32'hDEADBEEF, 32'h12345678);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_z", z, 32'd0);
    check("mrst_flags", 32'(Flags), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 15);
      if (sel < 13) op = 13'd1 << sel;
      else          op = 13'($urandom);
      a = $urandom;
      b = $urandom;
      issue_m(op, a, b);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_n.md
Name: alu_seq_n

Overview:
- Parametrised, multi-cycle successor to the 32-bit one-hot-opcode combinational ALU of the stack CPU datapath.
- Adds:
  - a WIDTH parameter;
  - valid/ready handshakes on input and output;
  - variable-amount shifts executed one bit per cycle;
  - an iterative shift-add multiply;
  - an illegal-opcode error output.
- Sits between the stack-top operand registers and the writeback stage; the controller stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 4).
- SHW, 5, shift-amount width; must equal ceil(log2(WIDTH)).

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  block can accept an operation
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B; y[SHW-1:0] is the shift amount
- OpCode  in  13  one-hot: 0 ADD, 1 SUB, 2 INX, 3 DCX, 4 CPX, 5 SHL, 6 SHR, 7 SRA, 8 AND, 9 OR, 10 XOR, 11 NOT, 12 MUL
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- z  out  WIDTH  result
- Flags  out  4  bit0 ZF, bit1 SF, bit2 OF, bit3 CF
- err  out  1  OpCode was not exactly one-hot; qualified by out_valid

Behaviour:
- States: IDLE, EXEC, DONE.
- Reset: state IDLE; z=0, Flags=0, err=0, out_valid=0, in_ready=1; internal counter and operand registers cleared.
- Reset has priority over everything; asserting rst in EXEC or DONE aborts and discards the operation.
- Handshake:
  - in_ready = (state==IDLE).
  - An operation is accepted on an edge where in_valid & in_ready.
  - out_valid = (state==DONE).
  - In DONE, z/Flags/err are held stable until an edge with out_ready=1, which returns to IDLE.
  - No new accept in DONE; minimum throughput is one op per 2 cycles.
- Single-cycle ops (ADD, SUB, INX, DCX, CPX, AND, OR, XOR, NOT; shifts with amount 0; illegal opcodes): result is computed and registered at the accept edge, IDLE->DONE; out_valid is high the following cycle.
- Shifts with amount k>0:
  - The accept edge loads x and k and enters EXEC.
  - Each EXEC edge shifts one bit and decrements the counter.
  - DONE is entered on the edge where the counter reaches 0, so out_valid follows k edges after accept.
- MUL:
  - Accept edge loads operands and enters EXEC.
  - WIDTH shift-add steps follow on a 2*WIDTH-bit unsigned accumulator.
  - DONE after WIDTH edges.
- Arithmetic, all results modulo 2^WIDTH:
  - ADD: x+y.
  - SUB: x-y.
  - INX: x+1.
  - DCX: x-1.
  - CPX: z=x (unchanged); Flags from x-y.
  - NOT: ~x.
  - AND/OR/XOR: bitwise x op y.
- Flags:
  - ZF = (z==0); for CPX, ZF = (x-y==0).
  - SF = MSB of the result (of x-y for CPX).
  - ADD/INX: CF = unsigned carry-out, OF = signed overflow.
  - SUB/DCX/CPX: CF = unsigned borrow (x<y, or x==0 for DCX), OF = signed overflow.
  - SHL/SHR/SRA: CF = last bit shifted out (0 when k=0); OF=0.
  - SRA replicates the MSB.
  - Logic ops and NOT: CF=OF=0.
  - MUL: z = low WIDTH bits; CF=OF=(high WIDTH bits != 0).
- Illegal OpCode (zero bits or more than one bit set): z=0, Flags=4'b0001, err=1, single-cycle.
- Input signals are ignored outside the accept edge; operands are captured, so x/y may change during EXEC.

Test Plan:
- WIDTH=32, ADD x=0x90000180 y=0x04000140 -> next cycle out_valid=1, z=0x940002C0, Flags=4'b0010, err=0.
- SUB with same operands -> z=0x8C000040, Flags=4'b0010. CPX x=y=0x1234 -> z=0x1234, Flags=4'b0001.
- SHL x=0x90000180 y=3 -> out_valid exactly 3 cycles after accept, z=0x80000C00, Flags=4'b0010. SHR x=0xF y=2 -> z=0x3, Flags=4'b1000. SRA x=0x90000180 y=3 -> z=0xF2000030.
- MUL x=0x00010000 y=0x00010003 -> out_valid 32 cycles after accept, z=0x00030000, Flags=4'b1100. Check in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> z/Flags/out_valid stable, in_ready=0. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
- rst pulsed at cycle 10 of a MUL -> next cycle all outputs at reset values, in_ready=1. OpCode=13'b0000000000011 -> err=1, z=0, Flags=4'b0001.
